// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory-mapped I/O port.
//   Address defaults for the hex, LED, button, switch and blank registers.
//   Widths: NUM_BTN, NUM_SW, DATA_W, ADDR_W.
//   btn_vec_t / sw_vec_t: per-button / per-switch bit vectors.
//   reg_sel_t: decoded register selector used by the read mux and write enables.
package mmio_pkg;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned NUM_SW  = 10;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 15;

  localparam logic [ADDR_W-1:0] HEX_ADDR_DEF   = 15'h6001;
  localparam logic [ADDR_W-1:0] LED_ADDR_DEF   = 15'h6002;
  localparam logic [ADDR_W-1:0] BTN_ADDR_DEF   = 15'h6003;
  localparam logic [ADDR_W-1:0] SW_ADDR_DEF    = 15'h6004;
  localparam logic [ADDR_W-1:0] BLANK_ADDR_DEF = 15'h6005;

  typedef logic [NUM_BTN-1:0] btn_vec_t;
  typedef logic [NUM_SW-1:0]  sw_vec_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_HEX,
    SEL_LED,
    SEL_BTN,
    SEL_SW,
    SEL_BLANK
  } reg_sel_t;

endpackage

// File: rtl/mmio_io_port_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus counter debounce for one
// active-low push-button.
//   clk, reset  : system clock, synchronous active-high reset
//   raw_n       : raw asynchronous button input, low = pressed
//   level       : debounced level, 1 = pressed
//   rise_pulse  : high for the single cycle whose clock edge takes level 0->1
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  logic w_pressed;
  logic w_diff;
  logic w_accept;

  assign w_pressed = ~r_sync[1];
  assign w_diff    = (w_pressed != r_level);
  // Accept on the edge that completes DEBOUNCE_CYCLES consecutive differing samples.
  assign w_accept  = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], raw_n};
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level      = r_level;
  assign rise_pulse = w_accept & w_pressed;

endmodule

// File: rtl/mmio_io_port.sv
// mmio_io_port: memory-mapped I/O peripheral on the CPU data-memory port.
//   clk, reset : system clock, synchronous active-high reset
//   addr_m     : CPU data address
//   out_m      : CPU write data
//   write_m    : CPU write strobe
//   in_m       : combinational read data for the addressed register, 0 if unmatched
//   btn        : raw push-buttons, active-low, asynchronous
//   sw         : raw slide switches, asynchronous
//   hex_value  : 16-bit value for the four hex digit decoders
//   led        : LED drive
//   hex_blank  : per-digit blank mask
// Optional feature macro HEX_BLANK_EN adds a writable blank-mask register at
// HEX_ADDR+4; without it hex_blank is tied low and that address is unmatched.
module mmio_io_port
  import mmio_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_CYCLES = 500000,
  parameter logic [ADDR_W-1:0]  HEX_ADDR        = HEX_ADDR_DEF,
  parameter logic [ADDR_W-1:0]  LED_ADDR        = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0]  BTN_ADDR        = BTN_ADDR_DEF,
  parameter logic [ADDR_W-1:0]  SW_ADDR         = SW_ADDR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       addr_m,
  input  logic [15:0]       out_m,
  input  logic              write_m,
  output logic [15:0]       in_m,
  input  logic [2:0]        btn,
  input  logic [9:0]        sw,
  output logic [15:0]       hex_value,
  output logic [9:0]        led,
  output logic [3:0]        hex_blank
);

`ifdef HEX_BLANK_EN
  localparam logic [ADDR_W-1:0] BLANK_ADDR = HEX_ADDR + 15'd4;
`endif

  logic [DATA_W-1:0] r_hex;
  logic [NUM_SW-1:0] r_led;
  btn_vec_t          r_sticky;
  sw_vec_t           r_sw_meta;
  sw_vec_t           r_sw_sync;

  btn_vec_t          w_level;
  btn_vec_t          w_rise;
  btn_vec_t          w_clr;
  reg_sel_t          w_sel;
  logic [3:0]        w_blank;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .raw_n      (btn[g]),
      .level      (w_level[g]),
      .rise_pulse (w_rise[g])
    );
  end

  always_comb begin
    w_sel = SEL_NONE;
    if (addr_m == HEX_ADDR)      w_sel = SEL_HEX;
    else if (addr_m == LED_ADDR) w_sel = SEL_LED;
    else if (addr_m == BTN_ADDR) w_sel = SEL_BTN;
    else if (addr_m == SW_ADDR)  w_sel = SEL_SW;
`ifdef HEX_BLANK_EN
    else if (addr_m == BLANK_ADDR) w_sel = SEL_BLANK;
`endif
  end

  assign w_clr = (write_m && (w_sel == SEL_BTN)) ? out_m[NUM_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex     <= '0;
      r_led     <= '0;
      r_sticky  <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      if (write_m && (w_sel == SEL_HEX)) r_hex <= out_m;
      if (write_m && (w_sel == SEL_LED)) r_led <= out_m[NUM_SW-1:0];
      // Set is OR'd in after the clear so a same-cycle rise wins over W1C.
      r_sticky <= (r_sticky & ~w_clr) | w_rise;
    end
  end

`ifdef HEX_BLANK_EN
  logic [3:0] r_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= '0;
    end else if (write_m && (w_sel == SEL_BLANK)) begin
      r_blank <= out_m[3:0];
    end
  end

  assign w_blank = r_blank;
`else
  assign w_blank = '0;
`endif

  always_comb begin
    in_m = '0;
    case (w_sel)
      SEL_HEX:   in_m = r_hex;
      SEL_LED:   in_m = {6'b0, r_led};
      SEL_BTN:   in_m = {10'b0, r_sticky, w_level};
      SEL_SW:    in_m = {6'b0, r_sw_sync};
      SEL_BLANK: in_m = {12'b0, w_blank};
      default:   in_m = '0;
    endcase
  end

  assign hex_value = r_hex;
  assign led       = r_led;
  assign hex_blank = w_blank;

endmodule

// File: tb/tb_mmio_io_port.sv
module tb_mmio_io_port;

  logic        clk;
  logic        reset;
  logic [14:0] addr_m;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] in_m;
  logic [2:0]  btn;
  logic [9:0]  sw;
  logic [15:0] hex_value;
  logic [9:0]  led;
  logic [3:0]  hex_blank;

  int unsigned n_checks;
  int unsigned n_errors;

  mmio_io_port #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr_m    (addr_m),
    .out_m     (out_m),
    .write_m   (write_m),
    .in_m      (in_m),
    .btn       (btn),
    .sw        (sw),
    .hex_value (hex_value),
    .led       (led),
    .hex_blank (hex_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addr_m  = a;
    out_m   = d;
    write_m = 1'b1;
    tick();
    write_m = 1'b0;
    out_m   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    addr_m   = '0;
    out_m    = '0;
    write_m  = 1'b0;
    btn      = 3'b111;
    sw       = '0;
    tick(3);
    addr_m = 15'h6003;
    chk("rst_hex", hex_value, 16'h0000);
    chk("rst_led", {6'b0, led}, 16'h0000);
    chk("rst_blank", {12'b0, hex_blank}, 16'h0000);
    chk("rst_btn_rd", in_m, 16'h0000);
    reset = 1'b0;
    tick();

    // Hex register write and zero-latency read.
    wr(15'h6001, 16'h1234);
    chk("hex_out", hex_value, 16'h1234);
    chk("hex_rd", in_m, 16'h1234);

    // LED write, then a write to an unmatched address.
    wr(15'h6002, 16'hFFFF);
    chk("led_out", {6'b0, led}, 16'h03FF);
    chk("led_rd", in_m, 16'h03FF);
    wr(15'h7000, 16'hFFFF);
    chk("unmapped_rd", in_m, 16'h0000);
    chk("unmapped_hex", hex_value, 16'h1234);
    chk("unmapped_led", {6'b0, led}, 16'h03FF);

    // Button 1 press: accepted on the 6th edge (2 sync + 4 debounce).
    addr_m = 15'h6003;
    btn[1] = 1'b0;
    tick(5);
    chk("btn1_early", in_m, 16'h0000);
    tick();
    chk("btn1_press", in_m, 16'h0012);
    btn[1] = 1'b1;
    tick(5);
    chk("btn1_hold", in_m, 16'h0012);
    tick();
    chk("btn1_release", in_m, 16'h0010);
    wr(15'h6003, 16'h0002);
    chk("btn1_w1c", in_m, 16'h0000);

    // 3-cycle glitch on button 0 must be rejected.
    btn[0] = 1'b0;
    tick(3);
    btn[0] = 1'b1;
    tick(2);
    chk("glitch_mid", in_m, 16'h0000);
    tick(6);
    chk("glitch_end", in_m, 16'h0000);

    // Button 2: W1C lands on the same edge that sets sticky[2]; set wins.
    btn[2] = 1'b0;
    tick(5);
    chk("btn2_early", in_m, 16'h0000);
    wr(15'h6003, 16'h0004);
    chk("set_beats_clr", in_m, 16'h0024);

    // Switch synchroniser: 2-cycle latency.
    sw     = 10'h2A5;
    addr_m = 15'h6004;
    tick();
    chk("sw_1cyc", in_m, 16'h0000);
    tick();
    chk("sw_2cyc", in_m, 16'h02A5);

    // Reset with hex, led, sticky loaded and button 2 still held.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_hex", hex_value, 16'h0000);
    chk("rst2_led", {6'b0, led}, 16'h0000);
    addr_m = 15'h6003;
    chk("rst2_btn", in_m, 16'h0000);
    tick(5);
    chk("reaccept_early", in_m, 16'h0000);
    tick();
    chk("reaccept", in_m, 16'h0024);

    // Blank register at 0x6005.
    wr(15'h6005, 16'h000A);
`ifdef HEX_BLANK_EN
    chk("blank_out", {12'b0, hex_blank}, 16'h000A);
    chk("blank_rd", in_m, 16'h000A);
`else
    chk("blank_out", {12'b0, hex_blank}, 16'h0000);
    chk("blank_rd", in_m, 16'h0000);
`endif
    chk("blank_hex_untouched", hex_value, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
